// File: rtl/xbar_rr_scheduler_if.sv
// Request/grant bundle between the crossbar datapath and its round-robin scheduler.
// The master side drives requests and output readiness; the slave side is the scheduler.
interface xbar_rr_scheduler_if #(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int DW = 2,
  parameter int SW = 2
);
  logic [N-1:0]    req;
  logic [N*DW-1:0] dest;
  logic [N-1:0]    last;
  logic [M-1:0]    out_ready;
  logic [N-1:0]    grant;
  logic [M*SW-1:0] sel;
  logic [M-1:0]    out_valid;
  logic [M*4-1:0]  beat_cnt;

  modport master (
    output req, dest, last, out_ready,
    input  grant, sel, out_valid, beat_cnt
  );

  modport slave (
    input  req, dest, last, out_ready,
    output grant, sel, out_valid, beat_cnt
  );
endinterface

// File: rtl/xbar_rr_scheduler.sv
// Per-output round-robin ownership scheduler for an N x M crossbar.
// Each output runs an IDLE/BUSY FSM; an owner keeps the output for a packet, capped at MAX_BEATS.
module xbar_rr_scheduler #(
  parameter int N         = 4,
  parameter int M         = 4,
  parameter int DW        = 2,
  parameter int SW        = 2,
  parameter int MAX_BEATS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  xbar_rr_scheduler_if.slave   bus
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [N-1:0]          grant_w;
  logic [M-1:0][SW-1:0]  sel_all;
  logic [M-1:0]          valid_all;
  logic [M-1:0][3:0]     bcnt_all;

  // An input has one dest, so at most one output can ever claim it.
  always_comb begin
    grant_w = '0;
    for (int o = 0; o < M; o++) begin
      if (valid_all[o]) grant_w[sel_all[o]] = 1'b1;
    end
  end

  assign bus.grant     = grant_w;
  assign bus.sel       = sel_all;
  assign bus.out_valid = valid_all;
  assign bus.beat_cnt  = bcnt_all;

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_out
      state_t          state_reg;
      logic [SW-1:0]   sel_reg;
      logic [SW-1:0]   ptr_reg;
      logic [3:0]      bcnt_reg;
      logic [CW-1:0]   cnt_reg;
      logic            valid_reg;
      logic [N-1:0]    cand;
      logic            pick_found;
      logic [SW-1:0]   pick_idx;
      logic [SW:0]     sum;
      logic [SW-1:0]   idx;
      logic            req_w;
      logic            last_w;
      logic            beat;
      logic            cap_hit;
      logic [SW-1:0]   ptr_next;

      always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++) begin
          cand[i] = bus.req[i] && (bus.dest[i*DW +: DW] == DW'(gi)) && !grant_w[i];
        end
      end

      // First candidate at or after the pointer, wrapping N-1 -> 0.
      always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
          sum = {1'b0, ptr_reg} + (SW+1)'(k);
          if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
          idx = sum[SW-1:0];
          if (!pick_found && cand[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx;
          end
        end
      end

      assign req_w    = bus.req[sel_reg];
      assign last_w   = bus.last[sel_reg];
      assign beat     = req_w && bus.out_ready[gi];
      assign cap_hit  = (cnt_reg == CW'(MAX_BEATS - 1));
      assign ptr_next = (sel_reg == SW'(N - 1)) ? '0 : sel_reg + SW'(1);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          sel_reg   <= '0;
          ptr_reg   <= '0;
          bcnt_reg  <= '0;
          cnt_reg   <= '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (pick_found) begin
                state_reg <= BUSY;
                valid_reg <= 1'b1;
                sel_reg   <= pick_idx;
                bcnt_reg  <= '0;
                cnt_reg   <= '0;
              end
            end
            BUSY: begin
              if (!req_w) begin
                state_reg <= IDLE;
                valid_reg <= 1'b0;
                ptr_reg   <= ptr_next;
              end else if (beat) begin
                if (bcnt_reg != 4'hF) bcnt_reg <= bcnt_reg + 4'd1;
                cnt_reg <= cnt_reg + CW'(1);
                if (last_w || cap_hit) begin
                  state_reg <= IDLE;
                  valid_reg <= 1'b0;
                  ptr_reg   <= ptr_next;
                end
              end
            end
            default: begin
              state_reg <= IDLE;
              valid_reg <= 1'b0;
            end
          endcase
        end
      end

      assign sel_all[gi]   = sel_reg;
      assign valid_all[gi] = valid_reg;
      assign bcnt_all[gi]  = bcnt_reg;
    end
  endgenerate
endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// Directed and randomized checks of xbar_rr_scheduler against an ownership-level reference model.
module tb_xbar_rr_scheduler;
  localparam int N = 4, M = 4, DW = 2, SW = 2, MAXB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  int m_owner[M];
  int m_ptr[M];
  int m_cnt[M];
  int m_sel[M];

  xbar_rr_scheduler_if #(.N(N), .M(M), .DW(DW), .SW(SW)) bus ();

  xbar_rr_scheduler #(.N(N), .M(M), .DW(DW), .SW(SW), .MAX_BEATS(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  function automatic void model_reset();
    for (int o = 0; o < M; o++) begin
      m_owner[o] = -1;
      m_ptr[o]   = 0;
      m_cnt[o]   = 0;
      m_sel[o]   = 0;
    end
  endfunction

  // One clock edge of the ownership rules, using the inputs present before the edge.
  function automatic void model_step();
    bit owned[N];
    for (int i = 0; i < N; i++) owned[i] = 0;
    for (int o = 0; o < M; o++) if (m_owner[o] >= 0) owned[m_owner[o]] = 1;
    for (int o = 0; o < M; o++) begin
      if (m_owner[o] < 0) begin
        bit found = 0;
        for (int k = 0; k < N; k++) begin
          int i = (m_ptr[o] + k) % N;
          int d = (bus.dest >> (i * DW)) & ((1 << DW) - 1);
          if (!found && bus.req[i] && d == o && !owned[i]) begin
            found = 1;
            m_owner[o] = i;
            m_sel[o]   = i;
            m_cnt[o]   = 0;
          end
        end
      end else begin
        int w = m_owner[o];
        bit rel = 0;
        if (!bus.req[w]) rel = 1;
        else if (bus.out_ready[o]) begin
          m_cnt[o]++;
          if (bus.last[w] || m_cnt[o] == MAXB) rel = 1;
        end
        if (rel) begin
          m_owner[o] = -1;
          m_ptr[o]   = (w + 1) % N;
        end
      end
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0]    eg;
    logic [M-1:0]    ev;
    logic [M*SW-1:0] es;
    logic [M*4-1:0]  eb;
    eg = '0; ev = '0; es = '0; eb = '0;
    for (int o = 0; o < M; o++) begin
      if (m_owner[o] >= 0) begin
        eg[m_owner[o]] = 1'b1;
        ev[o] = 1'b1;
      end
      es[o*SW +: SW] = SW'(m_sel[o]);
      eb[o*4 +: 4]   = 4'((m_cnt[o] > 15) ? 15 : m_cnt[o]);
    end
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("sel", 32'(bus.sel), 32'(es));
    chk("beat_cnt", 32'(bus.beat_cnt), 32'(eb));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    compare_all();
    $display("cyc %0d rst=%b req=%h dest=%h last=%h rdy=%h -> grant=%h valid=%h sel=%h bcnt=%h",
             cyc, rst, bus.req, bus.dest, bus.last, bus.out_ready,
             bus.grant, bus.out_valid, bus.sel, bus.beat_cnt);
    cyc++;
  endtask

  task automatic drive(input logic [3:0] r, input logic [7:0] d, input logic [3:0] l, input logic [3:0] rdy);
    bus.req = r; bus.dest = d; bus.last = l; bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_grant", 32'(bus.grant), 32'h0);
    chk("async_valid", 32'(bus.out_valid), 32'h0);
    chk("async_bcnt", 32'(bus.beat_cnt), 32'h0);
  endtask

  initial begin
    drive(4'hF, 8'hE4, 4'hF, 4'hF);
    model_reset();
    // Reset held with everything requesting
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_grant", 32'(bus.grant), 32'h0);
      chk("t1_valid", 32'(bus.out_valid), 32'h0);
      chk("t1_sel", 32'(bus.sel), 32'h0);
    end
    rst = 1'b0;

    // No conflict: every input to its own output
    step();
    chk("t2_grant", 32'(bus.grant), 32'hF);
    chk("t2_sel", 32'(bus.sel), 32'hE4);
    step();
    chk("t2_release", 32'(bus.grant), 32'h0);

    // Round-robin on output 2 between in0 and in2
    do_reset();
    drive(4'b0101, 8'h22, 4'hF, 4'b0100);
    step(); chk("t3_g0", 32'(bus.grant), 32'h1);
    step(); chk("t3_gap0", 32'(bus.grant), 32'h0);
    step(); chk("t3_g2", 32'(bus.grant), 32'h4);
    step(); chk("t3_gap1", 32'(bus.grant), 32'h0);
    step(); chk("t3_g0b", 32'(bus.grant), 32'h1);

    // Fairness cap: in1 never sends last, in3 waits
    do_reset();
    drive(4'b1010, 8'h00, 4'h0, 4'h1);
    step(); chk("t4_g1", 32'(bus.grant), 32'h2);
    for (int k = 0; k < 7; k++) begin
      step(); chk("t4_hold", 32'(bus.grant), 32'h2);
    end
    step();
    chk("t4_release", 32'(bus.grant), 32'h0);
    chk("t4_bcnt8", 32'(bus.beat_cnt[3:0]), 32'h8);
    step(); chk("t4_g3", 32'(bus.grant), 32'h8);

    // Backpressure then abort, pointer advances past the aborted owner
    do_reset();
    drive(4'b0001, 8'h05, 4'h0, 4'h0);
    step(); chk("t5_g0", 32'(bus.grant), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_hold", 32'(bus.grant), 32'h1);
      chk("t5_frozen", 32'(bus.beat_cnt[7:4]), 32'h0);
    end
    drive(4'b0001, 8'h05, 4'h0, 4'h2);
    step(); step();
    chk("t5_bcnt2", 32'(bus.beat_cnt[7:4]), 32'h2);
    drive(4'b0000, 8'h05, 4'h0, 4'h0);
    step(); chk("t5_abort", 32'(bus.out_valid), 32'h0);
    drive(4'b0011, 8'h05, 4'h0, 4'h2);
    step(); chk("t5_ptr", 32'(bus.grant), 32'h2);

    // Mid-ownership asynchronous reset
    do_reset();
    drive(4'b0001, 8'h00, 4'h0, 4'h1);
    step();
    step(); step(); step();
    chk("t6_bcnt3", 32'(bus.beat_cnt[3:0]), 32'h3);
    async_reset();
    step();
    rst = 1'b0;
    drive(4'hF, 8'h00, 4'h0, 4'h1);
    step(); chk("t6_lowest", 32'(bus.grant), 32'h1);

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      logic [3:0] r, l, rdy;
      for (int i = 0; i < N; i++) begin
        r[i]   = ($urandom_range(7) != 0);
        l[i]   = ($urandom_range(3) == 0);
        rdy[i] = ($urandom_range(3) != 0);
      end
      drive(r, 8'($urandom), l, rdy);
      if ($urandom_range(299) == 0) begin
        async_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
